// File: rtl/hangman_guess_checker.sv
// Hangman guess checker: latches a five-letter secret word and scores keypad guesses
// one position per cycle, reporting progress, misses and game outcome.
module hangman_guess_checker #(
    parameter int MAX_MISS = 6
) (
    input  logic        clk,
    input  logic        nRst,
    input  logic        word_load,
    input  logic [39:0] word_in,
    input  logic        ready,
    input  logic [7:0]  data,
    input  logic        game_end,
    output logic [39:0] display,
    output logic [4:0]  found_mask,
    output logic [25:0] guessed,
    output logic [2:0]  mistakes,
    output logic [2:0]  state,
    output logic        busy,
    output logic        hit,
    output logic        miss,
    output logic        dup,
    output logic        invalid,
    output logic        win,
    output logic        lose
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PLAY   = 3'd1,
        CHECK  = 3'd2,
        UPDATE = 3'd3,
        WIN    = 3'd4,
        LOSE   = 3'd5
    } state_t;

    localparam logic [2:0] MAX_MISS_L = 3'(MAX_MISS);

    state_t      state_q, state_d;
    logic [39:0] word_q, word_d;
    logic [7:0]  letter_q, letter_d;
    logic [2:0]  idx_q, idx_d;
    logic [4:0]  work_mask_q, work_mask_d;
    logic [4:0]  found_mask_q, found_mask_d;
    logic [25:0] guessed_q, guessed_d;
    logic [2:0]  mistakes_q, mistakes_d;
    logic        hit_q, hit_d;
    logic        miss_q, miss_d;
    logic        dup_q, dup_d;
    logic        invalid_q, invalid_d;

    logic        letter_valid;
    logic [4:0]  letter_idx;
    logic [4:0]  pos_hit;

    // 'A'..'Z' share bits [7:5]=010, so the low five bits minus one give the alphabet index.
    assign letter_valid = (data >= 8'h41) && (data <= 8'h5A);
    assign letter_idx   = data[4:0] - 5'd1;

    // Position gi lives in byte [39-8*gi -: 8] and maps to mask bit 4-gi.
    for (genvar gi = 0; gi < 5; gi++) begin : g_pos
        assign pos_hit[4-gi] = (idx_q == 3'(gi)) && (word_q[39-8*gi -: 8] == letter_q);
        assign display[39-8*gi -: 8] = found_mask_q[4-gi] ? word_q[39-8*gi -: 8] : 8'h5F;
    end

    always_comb begin
        state_d      = state_q;
        word_d       = word_q;
        letter_d     = letter_q;
        idx_d        = idx_q;
        work_mask_d  = work_mask_q;
        found_mask_d = found_mask_q;
        guessed_d    = guessed_q;
        mistakes_d   = mistakes_q;
        hit_d        = 1'b0;
        miss_d       = 1'b0;
        dup_d        = 1'b0;
        invalid_d    = 1'b0;

        if (game_end) begin
            state_d      = IDLE;
            idx_d        = 3'd0;
            work_mask_d  = 5'd0;
            found_mask_d = 5'd0;
            guessed_d    = 26'd0;
            mistakes_d   = 3'd0;
        end else if (word_load && (state_q == IDLE || state_q == WIN || state_q == LOSE)) begin
            state_d      = PLAY;
            word_d       = word_in;
            idx_d        = 3'd0;
            work_mask_d  = 5'd0;
            found_mask_d = 5'd0;
            guessed_d    = 26'd0;
            mistakes_d   = 3'd0;
        end else begin
            case (state_q)
                PLAY: begin
                    if (ready) begin
                        if (!letter_valid) begin
                            invalid_d = 1'b1;
                        end else if (guessed_q[letter_idx]) begin
                            dup_d = 1'b1;
                        end else begin
                            letter_d              = data;
                            guessed_d[letter_idx] = 1'b1;
                            idx_d                 = 3'd0;
                            work_mask_d           = 5'd0;
                            state_d               = CHECK;
                        end
                    end
                end
                CHECK: begin
                    work_mask_d = work_mask_q | pos_hit;
                    if (idx_q == 3'd4) begin
                        state_d = UPDATE;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
                UPDATE: begin
                    found_mask_d = found_mask_q | work_mask_q;
                    if (|work_mask_q) begin
                        hit_d = 1'b1;
                    end else begin
                        miss_d = 1'b1;
                        if (mistakes_q != MAX_MISS_L) begin
                            mistakes_d = mistakes_q + 3'd1;
                        end
                    end
                    if (found_mask_d == 5'b11111) begin
                        state_d = WIN;
                    end else if (mistakes_d == MAX_MISS_L) begin
                        state_d = LOSE;
                    end else begin
                        state_d = PLAY;
                    end
                end
                IDLE, WIN, LOSE: state_d = state_q;
                default:         state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q      <= IDLE;
            word_q       <= 40'd0;
            letter_q     <= 8'd0;
            idx_q        <= 3'd0;
            work_mask_q  <= 5'd0;
            found_mask_q <= 5'd0;
            guessed_q    <= 26'd0;
            mistakes_q   <= 3'd0;
            hit_q        <= 1'b0;
            miss_q       <= 1'b0;
            dup_q        <= 1'b0;
            invalid_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            word_q       <= word_d;
            letter_q     <= letter_d;
            idx_q        <= idx_d;
            work_mask_q  <= work_mask_d;
            found_mask_q <= found_mask_d;
            guessed_q    <= guessed_d;
            mistakes_q   <= mistakes_d;
            hit_q        <= hit_d;
            miss_q       <= miss_d;
            dup_q        <= dup_d;
            invalid_q    <= invalid_d;
        end
    end

    assign found_mask = found_mask_q;
    assign guessed    = guessed_q;
    assign mistakes   = mistakes_q;
    assign state      = state_q;
    assign busy       = (state_q != PLAY);
    assign hit        = hit_q;
    assign miss       = miss_q;
    assign dup        = dup_q;
    assign invalid    = invalid_q;
    assign win        = (state_q == WIN);
    assign lose       = (state_q == LOSE);

endmodule

// File: tb/tb_hangman_guess_checker.sv
// Directed bench for hangman_guess_checker: table of guesses on "APPLE" plus
// hand-written sequences for loss, ignored strobes, aborts and reset.
module tb_hangman_guess_checker;

    logic        clk = 1'b0;
    logic        nRst;
    logic        word_load;
    logic [39:0] word_in;
    logic        ready;
    logic [7:0]  data;
    logic        game_end;
    logic [39:0] display;
    logic [4:0]  found_mask;
    logic [25:0] guessed;
    logic [2:0]  mistakes;
    logic [2:0]  state;
    logic        busy, hit, miss, dup, invalid, win, lose;

    int checks = 0;
    int errors = 0;

    localparam logic [39:0] APPLE = 40'h4150504C45;
    localparam logic [39:0] HOUSE = 40'h484F555345;
    localparam logic [39:0] BLANK = 40'h5F5F5F5F5F;

    hangman_guess_checker #(.MAX_MISS(6)) dut (
        .clk(clk), .nRst(nRst), .word_load(word_load), .word_in(word_in),
        .ready(ready), .data(data), .game_end(game_end), .display(display),
        .found_mask(found_mask), .guessed(guessed), .mistakes(mistakes),
        .state(state), .busy(busy), .hit(hit), .miss(miss), .dup(dup),
        .invalid(invalid), .win(win), .lose(lose)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  data;
        int          waits;
        logic [3:0]  exp_pulse;   // {hit, miss, dup, invalid}
        logic [4:0]  exp_mask;
        logic [2:0]  exp_mis;
        logic [2:0]  exp_state;
        logic [39:0] exp_disp;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic load_word(input logic [39:0] w);
        @(negedge clk);
        word_in   = w;
        word_load = 1'b1;
        @(posedge clk);
        #1 word_load = 1'b0;
    endtask

    task automatic guess(input logic [7:0] d, input int waits);
        @(negedge clk);
        ready = 1'b1;
        data  = d;
        @(posedge clk);
        #1 ready = 1'b0;
        if (waits > 0) begin
            repeat (waits) @(posedge clk);
            #1;
        end
    endtask

    task automatic check_no_result(input string nm, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1 check(nm, {60'd0, hit, miss, dup, invalid}, 64'd0);
        end
    endtask

    initial begin
        nRst = 1'b0; word_load = 1'b0; word_in = 40'd0;
        ready = 1'b0; data = 8'd0; game_end = 1'b0;

        vecs[0] = '{8'h50, 6, 4'b1000, 5'b01100, 3'd0, 3'd1, 40'h5F50505F5F}; // P
        vecs[1] = '{8'h5A, 6, 4'b0100, 5'b01100, 3'd1, 3'd1, 40'h5F50505F5F}; // Z miss
        vecs[2] = '{8'h5A, 0, 4'b0010, 5'b01100, 3'd1, 3'd1, 40'h5F50505F5F}; // Z dup
        vecs[3] = '{8'h61, 0, 4'b0001, 5'b01100, 3'd1, 3'd1, 40'h5F50505F5F}; // 'a'
        vecs[4] = '{8'h41, 6, 4'b1000, 5'b11100, 3'd1, 3'd1, 40'h4150505F5F}; // A
        vecs[5] = '{8'h4C, 6, 4'b1000, 5'b11110, 3'd1, 3'd1, 40'h4150504C5F}; // L
        vecs[6] = '{8'h45, 6, 4'b1000, 5'b11111, 3'd1, 3'd4, 40'h4150504C45}; // E -> WIN
        vecs[7] = '{8'h42, 0, 4'b0000, 5'b11111, 3'd1, 3'd4, 40'h4150504C45}; // ignored in WIN

        // Reset state
        #1;
        check("rst_state", {61'd0, state}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd1);
        check("rst_disp", {24'd0, display}, {24'd0, BLANK});
        check("rst_flags", {57'd0, found_mask, win, lose}, 64'd0);
        @(negedge clk);
        nRst = 1'b1;

        load_word(APPLE);
        check("load_state", {61'd0, state}, 64'd1);
        check("load_busy", {63'd0, busy}, 64'd0);

        for (int i = 0; i < 8; i++) begin
            guess(vecs[i].data, vecs[i].waits);
            $display("vec %0d: data=%02h pulses=%b mask=%b mis=%0d state=%0d",
                     i, vecs[i].data, {hit, miss, dup, invalid}, found_mask, mistakes, state);
            check("pulse", {60'd0, hit, miss, dup, invalid}, {60'd0, vecs[i].exp_pulse});
            check("mask", {59'd0, found_mask}, {59'd0, vecs[i].exp_mask});
            check("mistakes", {61'd0, mistakes}, {61'd0, vecs[i].exp_mis});
            check("state", {61'd0, state}, {61'd0, vecs[i].exp_state});
            check("display", {24'd0, display}, {24'd0, vecs[i].exp_disp});
            check_no_result("pulse_end", 1);
        end
        check("win_lvl", {62'd0, win, lose}, 64'd2);
        check("guessed", {38'd0, guessed},
              64'((1 << 15) | (1 << 25) | (1 << 0) | (1 << 11) | (1 << 4)));

        // Six misses lead to LOSE; a fresh load then clears everything.
        load_word(APPLE);
        for (int k = 0; k < 6; k++) begin
            logic [7:0] miss_letters [6];
            miss_letters = '{8'h42, 8'h43, 8'h44, 8'h46, 8'h47, 8'h48};
            guess(miss_letters[k], 6);
            $display("miss %0d: data=%02h miss=%b mistakes=%0d state=%0d",
                     k, miss_letters[k], miss, mistakes, state);
            check("lose_miss", {63'd0, miss}, 64'd1);
            check("lose_mis", {61'd0, mistakes}, 64'(k + 1));
            check("lose_state", {61'd0, state}, (k == 5) ? 64'd5 : 64'd1);
        end
        check("lose_lvl", {62'd0, win, lose}, 64'd1);
        load_word(HOUSE);
        $display("load HOUSE: state=%0d mask=%b mis=%0d", state, found_mask, mistakes);
        check("house_state", {61'd0, state}, 64'd1);
        check("house_clear", {26'd0, guessed, found_mask, mistakes, win, lose}, 64'd0);
        check("house_disp", {24'd0, display}, {24'd0, BLANK});

        // ready during CHECK is ignored
        @(negedge clk);
        ready = 1'b1; data = 8'h4F;
        @(posedge clk);
        #1 data = 8'h55;
        @(posedge clk);
        #1 ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        $display("check-ready: hit=%b mask=%b guessed=%h", hit, found_mask, guessed);
        check("ckrdy_hit", {63'd0, hit}, 64'd1);
        check("ckrdy_mask", {59'd0, found_mask}, 64'b01000);
        check("ckrdy_guessed", {38'd0, guessed}, 64'(1 << 14));

        // game_end while comparing index 2
        @(negedge clk);
        ready = 1'b1; data = 8'h53;
        @(posedge clk);
        #1 ready = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 game_end = 1'b1;
        @(posedge clk);
        #1 game_end = 1'b0;
        $display("abort in CHECK: state=%0d mask=%b", state, found_mask);
        check("abort_state", {61'd0, state}, 64'd0);
        check("abort_clear", {28'd0, guessed, found_mask, mistakes}, 64'd0);
        check_no_result("abort_quiet", 6);

        // ready in IDLE is ignored
        guess(8'h41, 0);
        check("idle_ready", {57'd0, state, hit, miss, dup, invalid}, 64'd0);

        // game_end wins over word_load
        @(negedge clk);
        game_end = 1'b1; word_load = 1'b1; word_in = APPLE;
        @(posedge clk);
        #1 game_end = 1'b0; word_load = 1'b0;
        $display("abort+load: state=%0d", state);
        check("prio_state", {61'd0, state}, 64'd0);

        // Reset mid-CHECK
        load_word(APPLE);
        guess(8'h41, 2);
        nRst = 1'b0;
        #1;
        $display("reset mid-game: state=%0d busy=%b", state, busy);
        check("nrst_state", {61'd0, state}, 64'd0);
        check("nrst_busy", {63'd0, busy}, 64'd1);
        check("nrst_disp", {24'd0, display}, {24'd0, BLANK});
        check("nrst_clear", {26'd0, guessed, found_mask, mistakes, win, lose}, 64'd0);
        @(negedge clk);
        nRst = 1'b1;
        check_no_result("nrst_quiet", 8);
        check("nrst_idle", {61'd0, state}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hangman_guess_checker.md
HANGMAN_GUESS_CHECKER -- requirements
Module: hangman_guess_checker

Interface
REQ-001 Parameter: MAX_MISS, 6, number of misses that ends the game in LOSE; legal range 1-7.
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 nRst  input  1  reset, asynchronous, active-low.
REQ-004 word_load  input  1  one-cycle pulse that latches word_in and starts a game.
REQ-005 word_in  input  40  secret word: five ASCII uppercase letters; position 0 in [39:32], position 4 in [7:0].
REQ-006 ready  input  1  one-cycle strobe from the keypad side; a guessed letter is valid on data.
REQ-007 data  input  8  ASCII guessed letter, sampled only when ready=1.
REQ-008 game_end  input  1  abort request; returns the block to IDLE.
REQ-009 display  output  40  per position: the secret letter if found, else 8'h5F ('_'); same byte order as word_in.
REQ-010 found_mask  output  5  bit 4 = position 0 found, bit 0 = position 4 found.
REQ-011 guessed  output  26  bit k set once letter 'A'+k has been checked.
REQ-012 mistakes  output  3  miss count.
REQ-013 state  output  3  encoding IDLE=0, PLAY=1, CHECK=2, UPDATE=3, WIN=4, LOSE=5.
REQ-014 busy  output  1  high whenever state != PLAY.
REQ-015 hit, miss, dup, invalid  output  1 each  registered one-cycle result pulses.
REQ-016 win, lose  output  1 each  levels, high while state is WIN or LOSE respectively.

Function
REQ-017 IDLE: ready ignored; word_load latches word_in, clears found_mask, guessed and mistakes, and moves to PLAY on the next edge.
REQ-018 PLAY: ready=1 with data outside 8'h41-8'h5A pulses invalid on the next cycle; state stays PLAY, no other change.
REQ-019 PLAY: ready=1 with a valid letter whose guessed bit is already set pulses dup on the next cycle; state stays PLAY, mistakes unchanged.
REQ-020 PLAY: ready=1 with a valid new letter latches the letter, sets its guessed bit, and enters CHECK with position index 0.
REQ-021 CHECK: one position is compared per cycle, index 0 to 4; a match records the position in a working mask and sets a hit flag; after index 4 the block moves to UPDATE.
REQ-022 UPDATE: the working mask is ORed into found_mask in one cycle, so the display never shows a partial update.
REQ-023 UPDATE with no match: mistakes increments by 1, saturating at MAX_MISS.
REQ-024 UPDATE next state: WIN if found_mask becomes 5'b11111; else LOSE if mistakes becomes MAX_MISS; else PLAY.
REQ-025 hit (match) or miss (no match) is high for exactly the one cycle following UPDATE.
REQ-026 Latency: the found_mask, mistakes and hit/miss update is visible 6 rising edges after the edge that sampled ready.
REQ-027 A letter that appears at several positions sets every matching position; it counts as a single hit.
REQ-028 ready is ignored in every state other than PLAY; no queueing.
REQ-029 word_load is honoured only in IDLE, WIN and LOSE (starts a new game as in REQ-017); it is ignored in PLAY, CHECK and UPDATE.
REQ-030 game_end=1 in any state: next edge enters IDLE and clears found_mask, guessed, mistakes and all pulses; the latched word is kept.
REQ-031 Priority within one cycle: game_end > word_load > ready.
REQ-032 display is combinational from the latched word and found_mask.
REQ-033 WIN and LOSE hold until word_load or game_end.

Reset
REQ-034 nRst=0 immediately forces state=IDLE, latched word=0, found_mask=0, guessed=0, mistakes=0, hit=miss=dup=invalid=0, win=lose=0, busy=1, and display=all 8'h5F.
REQ-035 Reset asserted mid-CHECK discards the in-flight guess; no pulse is emitted after release.

Verification
REQ-036 Scenario: load "APPLE" (41 50 50 4C 45), guess 'P'. Required: 6 edges later found_mask=01100, hit=1 for 1 cycle, mistakes=0, display="_PP__".
REQ-037 Scenario: in "APPLE", guess 'Z', then 'Z' again. Required: first guess gives miss=1 and mistakes=1; the second gives dup=1 on the next cycle and mistakes stays 1.
REQ-038 Scenario: guesses A, P, L, E in sequence. Required: after E, state=WIN, win=1, found_mask=11111; a subsequent ready is ignored.
REQ-039 Scenario: six distinct non-word letters with MAX_MISS=6. Required: state=LOSE, mistakes=6; a word_load of "HOUSE" then gives PLAY with all progress cleared.
REQ-040 Scenario: ready with data=8'h61 ('a'), and separately ready while in CHECK. Required: the first gives invalid=1 only; the second has no effect.
REQ-041 Scenario: game_end in CHECK index 2, and separately game_end together with word_load. Required: both give IDLE on the next edge with no hit or miss pulse; an nRst pulse mid-game gives the REQ-034 values.
